fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: memory address width, depth 2**ADDR_WIDTH.
REQ-003 SHALL have `rclk  in  1`: read-domain clock; the only clock in the block.
REQ-004 SHALL have `rrst  in  1`: reset, synchronous to rclk, active-high.
REQ-005 SHALL have `wptr_gray  in  ADDR_WIDTH+1`: write pointer, Gray-coded, from the write domain (asynchronous to rclk).
REQ-006 SHALL have `rptr_gray  out  ADDR_WIDTH+1`: registered read pointer, Gray-coded, to the write domain.
REQ-007 SHALL have `raddr  out  ADDR_WIDTH`: memory read address, equal to rbin[ADDR_WIDTH-1:0].
REQ-008 SHALL have `ren  out  1`: memory read enable; the memory registers data at the rclk edge where ren=1.
REQ-009 SHALL have `mem_rdata  in  DATA_WIDTH`: memory read data, valid the cycle after ren.
REQ-010 SHALL have `rdata  out  DATA_WIDTH`: head-of-queue data to the consumer.
REQ-011 SHALL have `rvalid  out  1`: rdata holds a valid word.
REQ-012 SHALL have `rready  in  1`: the consumer accepts the word when rvalid&&rready at the rclk edge.
REQ-013 SHALL have `rempty  out  1`: registered FIFO-storage empty flag. It does not include words already held in the output buffer.

Function
REQ-014 SHALL pass wptr_gray through a two-flop synchronizer (rq1, rq2) before any use; no other logic touches wptr_gray.
REQ-015 SHALL keep binary pointer rbin, ADDR_WIDTH+1 bits, which increments by 1 at each edge where ren=1 and wraps modulo 2**(ADDR_WIDTH+1).
REQ-016 SHALL compute rgraynext = (rbinnext>>1)^rbinnext, and register rptr_gray <= rgraynext every cycle.
REQ-017 SHALL register rempty <= (rgraynext == rq2) every cycle.
REQ-018 SHALL hold words in a 2-entry output queue, where occ ∈ {0,1,2}; rvalid = (occ!=0) and rdata = the oldest entry.
REQ-019 SHALL keep an inflight flag, set at the edge where ren=1 and cleared the next edge, when mem_rdata is pushed into the queue.
REQ-020 SHALL assert ren = !rempty && (occ + inflight - pop) < 2, combinationally, where pop = rvalid&&rready.
REQ-021 SHALL never lose a word or overflow the queue: push and pop in the same cycle leave occ unchanged, and ordering is strictly FIFO.
REQ-022 SHALL sustain one word per rclk at steady state when the FIFO is non-empty and rready is held high.
REQ-023 SHALL have the following latency, for a wptr_gray change stable before edge E1 with the FIFO empty:
- rq2 updated at E2
- rempty low after E3
- ren high in the E3–E4 cycle
- rvalid high after E5
REQ-024 SHALL handle the last word: when rbinnext reaches the synchronized write pointer, rempty rises at that same edge and ren drops in the following cycle.
REQ-025 SHALL handle wrap-around: full/empty disambiguation relies on the MSB of the (ADDR_WIDTH+1)-bit pointers, and no special case exists at wrap.
REQ-026 SHALL make rdata and rvalid stable while rvalid&&!rready; rready with rvalid=0 has no effect.

Reset
REQ-027 SHALL clear, at the edge where rrst=1 (outputs valid the following cycle):
- rbin, rptr_gray, rq1, rq2, occ, inflight = 0
- rempty = 1
- rvalid = 0
- ren = 0
- rdata = 0
REQ-028 SHALL discard queued and in-flight words on rrst asserted mid-operation; the write side is reset concurrently by the system.
REQ-029 SHALL hold ren=0 while rrst=1, and all reset values hold until the first edge after rrst deasserts.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-030 SHALL cover reset: rrst high 2 cycles -> rempty=1, rvalid=0, rptr_gray=5'b00000, ren=0.
REQ-031 SHALL cover single word: wptr_gray 0->1 with memory[0]=8'hA5 -> rempty low after E3, ren one cycle with raddr=0, rvalid=1 and rdata=8'hA5 after E5; with rready=1, rptr_gray=5'b00001 and rempty=1 thereafter.
REQ-032 SHALL cover streaming: wptr_gray advanced to Gray(16), memory[i]=i, rready=1 -> 16 consecutive words 0..15, one per cycle after first valid; final rptr_gray=Gray(16)=5'b11000.
REQ-033 SHALL cover backpressure: 4 words queued, rready=0 for 10 cycles -> occ=2, ren=0, rdata=0 stable; on rready=1, the words are delivered 0,1,2,3 in order without gaps.
REQ-034 SHALL cover wrap-around: 40 words pushed/popped in bursts of 5 -> pointer passes 31->0, data order intact, rempty=1 at end with rptr_gray=Gray(8).
REQ-035 SHALL cover mid-stream reset: rrst asserted while occ=2 and inflight=1 -> next cycle rvalid=0, rempty=1, rptr_gray=0; no stale word appears after release.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read side of an asynchronous FIFO: synchronizes the write pointer, tracks the read pointer,
// and prefetches memory words into a 2-entry output queue so one word per cycle can be streamed.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rempty
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         rq1_q, rq2_q;
    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rptr_gray_q, rgray_d;
    logic                  rempty_q;
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
    logic                  pop, push, ren_c;
    logic [2:0]            fill;

    always_comb begin
        pop    = (occ_q != 2'd0) && rready;
        push   = inflight_q;
        // Words that will occupy the queue once the outstanding read lands, after this cycle's pop.
        fill   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        ren_c  = !rrst && !rempty_q && (fill < 3'd2);
        rbin_d = rbin_q + {{ADDR_WIDTH{1'b0}}, ren_c};
        rgray_d = (rbin_d >> 1) ^ rbin_d;
    end

    always_comb begin
        occ_d = occ_q;
        q0_d  = q0_q;
        q1_d  = q1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) q0_d = mem_rdata;
                else               q1_d = mem_rdata;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                q0_d  = q1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    q0_d = mem_rdata;
                end else begin
                    q0_d = q1_q;
                    q1_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1_q       <= '0;
            rq2_q       <= '0;
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            rempty_q    <= 1'b1;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            q0_q        <= '0;
            q1_q        <= '0;
        end else begin
            rq1_q       <= wptr_gray;
            rq2_q       <= rq1_q;
            rbin_q      <= rbin_d;
            rptr_gray_q <= rgray_d;
            rempty_q    <= (rgray_d == rq2_q);
            inflight_q  <= ren_c;
            occ_q       <= occ_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
        end
    end

    assign rptr_gray = rptr_gray_q;
    assign raddr     = rbin_q[ADDR_WIDTH-1:0];
    assign ren       = ren_c;
    assign rdata     = q0_q;
    assign rvalid    = (occ_q != 2'd0);
    assign rempty    = rempty_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural memory and write side, scoreboard queue of expected words,
// directed latency/boundary scenarios plus randomized traffic.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic [4:0] wptr_gray = '0;
    logic [4:0] rptr_gray;
    logic [3:0] raddr;
    logic       ren;
    logic [7:0] mem_rdata = '0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready = 1'b0;
    logic       rempty;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int         wbin = 0;
    int         pop_cnt = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = '0;

    fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .rptr_gray (rptr_gray),
        .raddr     (raddr),
        .ren       (ren),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rempty    (rempty)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) if (ren) mem_rdata <= mem[raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Every accepted word must be the oldest one written; stalled output must not change.
    always @(negedge rclk) begin
        if (!rrst) begin
            if (hold_prev) begin
                chk("hold_valid", rvalid, 1);
                chk("hold_data", rdata, hold_data);
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) chk("unexpected_word", rvalid, 0);
                else begin
                    chk("data", rdata, exp_q.pop_front());
                    pop_cnt++;
                end
            end
            hold_prev = rvalid && !rready;
            hold_data = rdata;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        wptr_gray = '0;
        wbin = 0;
        exp_q.delete();
        pop_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rempty", rempty, 1);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rptr", rptr_gray, 0);
            chk("rst_ren", ren, 0);
            chk("rst_rdata", rdata, 0);
        end
        rrst = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] val);
        for (int i = 0; i < 500 && (wbin - pop_cnt) >= 16; i++) tick();
        chk("write_room", ((wbin - pop_cnt) < 16), 1);
        mem[wbin % 16] = val;
        wbin++;
        wptr_gray = gray(wbin[4:0]);
        exp_q.push_back(val);
    endtask

    task automatic drain();
        rready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // reset and single word latency
        do_reset();
        write_word(8'hA5);
        tick(); chk("sw_e1_rempty", rempty, 1);
        tick(); chk("sw_e2_rempty", rempty, 1);
        tick(); chk("sw_e3_rempty", rempty, 0);
        chk("sw_e3_ren", ren, 1);
        chk("sw_e3_raddr", raddr, 0);
        tick(); chk("sw_e4_ren", ren, 0);
        chk("sw_e4_rvalid", rvalid, 0);
        tick(); chk("sw_e5_rvalid", rvalid, 1);
        chk("sw_e5_rdata", rdata, 8'hA5);
        rready = 1'b1;
        tick(); chk("sw_done_rvalid", rvalid, 0);
        chk("sw_rptr", rptr_gray, 5'b00001);
        chk("sw_rempty", rempty, 1);
        chk("sw_count", pop_cnt, 1);

        // streaming 16 words back-to-back
        do_reset();
        rready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(i[7:0]);
        for (int i = 0; i < 10 && !rvalid; i++) tick();
        chk("stream_start", rvalid, 1);
        for (int i = 0; i < 16; i++) begin
            chk("stream_gap", rvalid, 1);
            tick();
        end
        chk("stream_end", rvalid, 0);
        chk("stream_rptr", rptr_gray, 5'b11000);
        chk("stream_rempty", rempty, 1);
        chk("stream_count", pop_cnt, 16);

        // backpressure
        do_reset();
        rready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(i[7:0]);
        for (int i = 0; i < 7; i++) tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_ren", ren, 0);
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 0);
            tick();
        end
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_nogap", rvalid, 1);
            tick();
        end
        chk("bp_end", rvalid, 0);
        drain();
        chk("bp_count", pop_cnt, 4);

        // wrap-around in bursts of five with random consumer
        do_reset();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 5; k++) write_word(8'($urandom));
            for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
                rready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        drain();
        chk("wrap_count", pop_cnt, 40);
        chk("wrap_rempty", rempty, 1);
        chk("wrap_rptr", rptr_gray, 5'b01100);

        // mid-stream reset with words queued and a read outstanding
        do_reset();
        rready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'h50 + i[7:0]);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_pre_rvalid", rvalid, 1);
        do_reset();
        rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mr_no_stale", rvalid, 0);
        end
        for (int i = 0; i < 3; i++) write_word(8'hC0 + i[7:0]);
        drain();
        chk("mr_count", pop_cnt, 3);

        // random soak
        for (int i = 0; i < 400; i++) begin
            rready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && (wbin - pop_cnt) < 16) write_word(8'($urandom));
            tick();
        end
        drain();
        chk("soak_rempty", rempty, 1);
        chk("soak_rptr", rptr_gray, gray(wbin[4:0]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
